tetris_field: RTL

Parametrised playfield engine for the Tetris datapath. It stores a W×H board of per-cell piece kinds and accepts locked-piece masks through a valid/ready handshake. After each lock it clears any number of full rows, injects queued garbage rows from the bottom, detects top-out and keeps a BCD score. It sits between the piece/move controller, which owns the falling piece and checks collisions against `occ`, and the VGA renderer, which reads cells through `rd_*`.

---
 rtl/tetris_field.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tetris_field.sv
// tetris_field: W x H playfield engine. Stores per-cell piece kinds, accepts
// locked-piece masks, clears full rows, injects garbage rows from the bottom,
// flags top-out and keeps a saturating BCD score.
// Build macro TETRIS_FIELD_GARBAGE_EN: when defined, the garbage FIFO and the
// GARB state are built; otherwise garbage inputs are ignored.
// GQ_DEPTH must be a power of two and at least 2.
module tetris_field #(
  parameter int W            = 10,
  parameter int H            = 20,
  parameter int KIND_W       = 3,
  parameter int GARB_KIND    = 7,
  parameter int GQ_DEPTH     = 4,
  parameter int SCORE_DIGITS = 4,
  localparam int LW          = $clog2(H + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clr_i,
  input  logic                      lock_valid,
  output logic                      lock_ready,
  input  logic [W*H-1:0]            lock_mask,
  input  logic [KIND_W-1:0]         lock_kind,
  input  logic                      garb_valid,
  output logic                      garb_ready,
  input  logic [W-1:0]              garb_row,
  input  logic [3:0]                rd_x,
  input  logic [4:0]                rd_y,
  output logic [KIND_W-1:0]         rd_kind,
  output logic [W*H-1:0]            occ,
  output logic                      busy,
  output logic                      done,
  output logic [LW-1:0]             lines,
  output logic                      top_out,
  output logic [4*SCORE_DIGITS-1:0] score
);
  localparam int RW = $clog2(H);
  localparam int SW = 4 * SCORE_DIGITS;

  typedef enum logic [2:0] {IDLE, LOCK, SCAN, GARB, DONE} state_e;
  typedef logic [W-1:0][KIND_W-1:0] row_t;

  state_e            state_q, state_d;
  row_t [H-1:0]      board_q, board_d;
  logic [W*H-1:0]    mask_q, mask_d;
  logic [KIND_W-1:0] kind_q, kind_d, rd_kind_q, rd_kind_d;
  logic [RW-1:0]     row_q, row_d;
  logic [LW-1:0]     cnt_q, cnt_d, lines_q, lines_d;
  logic [SW-1:0]     score_q, score_d;
  logic [H-1:0]      row_full;
  logic [3:0]        inc;

`ifdef TETRIS_FIELD_GARBAGE_EN
  localparam int GW = $clog2(GQ_DEPTH);
  logic [GQ_DEPTH-1:0][W-1:0] gq_q, gq_d;
  logic [GW-1:0]              gq_wr_q, gq_wr_d, gq_rd_q, gq_rd_d;
  logic [GW:0]                gq_cnt_q, gq_cnt_d;
  logic                       top_q, top_d, gq_push, gq_pop;
  assign garb_ready = (gq_cnt_q != (GW+1)'(GQ_DEPTH));
  assign top_out    = top_q;
`else
  logic unused_garb;
  assign unused_garb = ^{garb_valid, garb_row, GARB_KIND[0], GQ_DEPTH[0]};
  assign garb_ready  = 1'b0;
  assign top_out     = 1'b0;
`endif

  assign lock_ready = (state_q == IDLE) && !top_out && !clr_i;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign lines      = lines_q;
  assign score      = score_q;
  assign rd_kind    = rd_kind_q;

  // BCD add of a small increment; any carry out of the top digit pins all-9s
  function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] a, input logic [3:0] inc_i);
    logic [SW-1:0] r;
    logic [4:0]    s;
    logic          c;
    r = a;
    c = 1'b0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      s = {1'b0, a[4*i +: 4]} + ((i == 0) ? {1'b0, inc_i} : {4'd0, c});
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    if (c) r = {SCORE_DIGITS{4'd9}};
    return r;
  endfunction

  // occupancy map and per-row full flags straight off the board registers
  always_comb begin
    occ      = '0;
    row_full = '1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        occ[y*W + x] = |board_q[y][x];
        if (board_q[y][x] == '0) row_full[y] = 1'b0;
      end
  end

  // score increment for the number of rows cleared in this sequence
  always_comb begin
    inc = 4'd0;
    if (cnt_q >= LW'(4))      inc = 4'd8;
    else if (cnt_q == LW'(3)) inc = 4'd5;
    else if (cnt_q == LW'(2)) inc = 4'd3;
    else if (cnt_q == LW'(1)) inc = 4'd1;
  end

  // out-of-range reads return empty
  always_comb begin
    rd_kind_d = '0;
    if (int'(rd_x) < W && int'(rd_y) < H) rd_kind_d = board_q[rd_y][rd_x];
  end

  // lock / scan / garbage sequencer, FIFO bookkeeping and new-game clear
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    mask_d  = mask_q;
    kind_d  = kind_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    score_d = score_q;
`ifdef TETRIS_FIELD_GARBAGE_EN
    gq_d     = gq_q;
    gq_wr_d  = gq_wr_q;
    gq_rd_d  = gq_rd_q;
    gq_cnt_d = gq_cnt_q;
    top_d    = top_q;
    gq_push  = garb_valid && garb_ready && !clr_i;
    gq_pop   = 1'b0;
`endif
    case (state_q)
      IDLE: if (lock_valid && lock_ready) begin
        mask_d  = lock_mask;
        kind_d  = lock_kind;
        state_d = LOCK;
      end
      LOCK: begin
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++)
            if (mask_q[y*W + x]) board_d[y][x] = kind_q;
        row_d   = RW'(H - 1);
        cnt_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (row_full[row_q]) begin
          // drop everything above row_q by one; row_q is re-examined next cycle
          for (int y = 1; y < H; y++)
            if (RW'(y) <= row_q) board_d[y] = board_q[y-1];
          board_d[0] = '0;
          cnt_d      = cnt_q + 1'b1;
        end else if (row_q == '0) begin
`ifdef TETRIS_FIELD_GARBAGE_EN
          state_d = (gq_cnt_q != '0) ? GARB : DONE;
`else
          state_d = DONE;
`endif
        end else begin
          row_d = row_q - 1'b1;
        end
      end
      GARB: begin
`ifdef TETRIS_FIELD_GARBAGE_EN
        gq_pop = 1'b1;
        if (|occ[W-1:0]) top_d = 1'b1;
        for (int y = 0; y < H - 1; y++) board_d[y] = board_q[y+1];
        for (int x = 0; x < W; x++)
          board_d[H-1][x] = gq_q[gq_rd_q][x] ? KIND_W'(GARB_KIND) : '0;
        // a push landing in the last pop cycle keeps us draining
        if (gq_cnt_q == (GW+1)'(1) && !gq_push) state_d = DONE;
`else
        state_d = DONE;
`endif
      end
      DONE: begin
        score_d = bcd_add(score_q, inc);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state_q != DONE) lines_d = cnt_q;
`ifdef TETRIS_FIELD_GARBAGE_EN
    if (gq_push) begin
      gq_d[gq_wr_q] = garb_row;
      gq_wr_d       = gq_wr_q + 1'b1;
    end
    if (gq_pop) gq_rd_d = gq_rd_q + 1'b1;
    if (gq_push && !gq_pop)      gq_cnt_d = gq_cnt_q + 1'b1;
    else if (!gq_push && gq_pop) gq_cnt_d = gq_cnt_q - 1'b1;
`endif
    if (clr_i) begin
      state_d = IDLE;
      board_d = '0;
      cnt_d   = '0;
      lines_d = '0;
      score_d = '0;
`ifdef TETRIS_FIELD_GARBAGE_EN
      gq_wr_d  = '0;
      gq_rd_d  = '0;
      gq_cnt_d = '0;
      top_d    = 1'b0;
`endif
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      board_q   <= '0;
      mask_q    <= '0;
      kind_q    <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      lines_q   <= '0;
      score_q   <= '0;
      rd_kind_q <= '0;
`ifdef TETRIS_FIELD_GARBAGE_EN
      gq_q      <= '0;
      gq_wr_q   <= '0;
      gq_rd_q   <= '0;
      gq_cnt_q  <= '0;
      top_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      mask_q    <= mask_d;
      kind_q    <= kind_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      lines_q   <= lines_d;
      score_q   <= score_d;
      rd_kind_q <= rd_kind_d;
`ifdef TETRIS_FIELD_GARBAGE_EN
      gq_q      <= gq_d;
      gq_wr_q   <= gq_wr_d;
      gq_rd_q   <= gq_rd_d;
      gq_cnt_q  <= gq_cnt_d;
      top_q     <= top_d;
`endif
    end
  end
endmodule
